// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single synchronous write port between the CPU
// writeback stage and a debug/loader master. It can optionally sequence a
// clear of r1..r31. Writes that target r0 are consumed without reaching the
// regfile, so r0 stays zero.
//
// Build option: define RF_CLEAR_EN to include the CLEAR state, the clear
// pointer and the clr_* logic. Without it, clr_start is ignored and
// clr_busy/clr_done are tied low.
//
// Parameters:
//   STARVE_LIMIT  conflicts the debug buffer may lose in a row before it
//                 wins one (legal 1..255)
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cpu_wen/cpu_waddr/cpu_wdata   CPU writeback request, held while stalled
//   cpu_stall                     CPU write not performed this cycle
//   dbg_valid/dbg_ready           debug beat handshake into the holding buffer
//   dbg_waddr/dbg_wdata           debug beat payload
//   clr_start/clr_busy/clr_done   clear sequence control and status
//   rf_wen/rf_waddr/rf_wdata      regfile write port
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wen,
  input  logic [4:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [4:0]  dbg_waddr,
  input  logic [31:0] dbg_wdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // Debug holding buffer: a single {addr, data} entry.
  logic        buf_full;
  logic [4:0]  buf_addr;
  logic [31:0] buf_data;
  logic [7:0]  starve_cnt;

  logic        in_clear;
  logic [4:0]  clr_ptr;
  logic        clr_done_q;

  logic        grant_cpu;
  logic        grant_buf;
  logic        sel_valid;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

`ifdef RF_CLEAR_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      clr_ptr    <= 5'd1;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clr_ptr == 5'd31) begin
            state      <= ST_IDLE;
            clr_ptr    <= 5'd1;
            clr_done_q <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_clear = (state == ST_CLEAR);
`else
  logic clr_start_unused;

  assign clr_start_unused = clr_start;
  assign in_clear         = 1'b0;
  assign clr_ptr          = 5'd1;
  assign clr_done_q       = 1'b0;
`endif

  // Arbitration. The CPU normally wins. The buffer wins when it is alone, or
  // when it has already lost STARVE_LIMIT conflicts in a row. Nothing is
  // granted while a clear is running.
  always_comb begin
    grant_buf = 1'b0;
    grant_cpu = 1'b0;
    if (!in_clear) begin
      grant_buf = buf_full && (!cpu_wen || (starve_cnt == LIMIT));
      grant_cpu = cpu_wen && !grant_buf;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = 5'd0;
    sel_data  = 32'd0;
    if (in_clear) begin
      sel_valid = 1'b1;
      sel_addr  = clr_ptr;
    end else if (grant_cpu) begin
      sel_valid = 1'b1;
      sel_addr  = cpu_waddr;
      sel_data  = cpu_wdata;
    end else if (grant_buf) begin
      sel_valid = 1'b1;
      sel_addr  = buf_addr;
      sel_data  = buf_data;
    end
  end

  // A granted write to r0 still consumes its request; it just never
  // reaches the regfile.
  assign rf_wen    = sel_valid && (sel_addr != 5'd0);
  assign rf_waddr  = rf_wen ? sel_addr : 5'd0;
  assign rf_wdata  = rf_wen ? sel_data : 32'd0;
  assign cpu_stall = cpu_wen && !grant_cpu;
  assign clr_busy  = in_clear;
  assign clr_done  = clr_done_q;

  // Handshake: a debug beat transfers on a rising edge where
  // dbg_valid && dbg_ready. dbg_ready depends only on state (buffer empty),
  // never on dbg_valid. A buffer drained at an edge refills no earlier than
  // the following cycle.
  assign dbg_ready = !buf_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full   <= 1'b0;
      buf_addr   <= 5'd0;
      buf_data   <= 32'd0;
      starve_cnt <= 8'd0;
    end else begin
      if (dbg_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_addr <= dbg_waddr;
        buf_data <= dbg_wdata;
      end else if (grant_buf) begin
        buf_full <= 1'b0;
      end

      if (grant_buf) begin
        starve_cnt <= 8'd0;
      end else if (!in_clear && cpu_wen && buf_full && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
`timescale 1ns/1ps
module tb_rf_write_arbiter;

  localparam int STARVE_LIMIT = 4;
`ifdef RF_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cpu_wen;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_waddr;
  logic [31:0] dbg_wdata;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  rf_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Mock regfile fed by the DUT write port.
  logic [31:0] mock_rf [32];
  int          r0_writes = 0;
  always @(posedge clk) begin
    if (rf_wen) begin
      mock_rf[rf_waddr] <= rf_wdata;
      if (rf_waddr == 5'd0) r0_writes <= r0_writes + 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] dut_out();
    return {22'd0, cpu_stall, dbg_ready, clr_busy, clr_done, rf_wen, rf_waddr, rf_wdata};
  endfunction

  function automatic logic [63:0] mk_out(input logic st, input logic rdy, input logic busy,
                                         input logic done, input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd);
    return {22'd0, st, rdy, busy, done, we, wa, wd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    cpu_wen = 1'b0; cpu_waddr = 5'd0; cpu_wdata = 32'd0;
    dbg_valid = 1'b0; dbg_waddr = 5'd0; dbg_wdata = 32'd0;
    clr_start = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_out", dut_out(), mk_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One cycle with the current inputs; compare outputs mid-cycle.
  task automatic cyc_chk(input string name, input logic [63:0] exp);
    @(negedge clk);
    chk(name, dut_out(), exp);
    @(posedge clk); #1;
  endtask

  task automatic cpu_drive(input logic [4:0] a, input logic [31:0] d);
    cpu_wen = 1'b1; cpu_waddr = a; cpu_wdata = d;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic cw; logic [4:0] ca; logic [31:0] cd;
    logic dv; logic [4:0] da; logic [31:0] dd;
    logic st; logic rdy; logic we; logic [4:0] wa; logic [31:0] wd;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                              input logic dv, input logic [4:0] da, input logic [31:0] dd,
                              input logic st, input logic rdy, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd);
    vec_t v;
    v.cw = cw; v.ca = ca; v.cd = cd; v.dv = dv; v.da = da; v.dd = dd;
    v.st = st; v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          lost;
  } beat_t;
  beat_t       pend_q[$];
  bit          m_clear;
  int          m_clr_n;
  bit          m_done;
  logic [31:0] exp_rf [32];
  bit          exp_valid [32];
  logic [36:0] exp_q[$];

  logic        e_stall, e_ready, e_busy, e_done, e_wen;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          e_buf_win;

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    m_clear = 1'b0; m_clr_n = 0; m_done = 1'b0;
    e_stall = 1'b0; e_ready = 1'b1;
    for (int i = 0; i < 32; i++) exp_valid[i] = 1'b0;
  endtask

  task automatic model_eval();
    bit          have;
    logic [4:0]  a;
    logic [31:0] d;
    have = 1'b0; a = 5'd0; d = 32'd0;
    e_ready = (pend_q.size() == 0);
    e_busy = m_clear;
    e_done = m_done;
    e_buf_win = 1'b0;
    if (m_clear) begin
      have = 1'b1;
      a = 5'(m_clr_n + 1);
      e_stall = cpu_wen;
    end else begin
      if (pend_q.size() > 0 && (!cpu_wen || pend_q[0].lost >= STARVE_LIMIT)) begin
        e_buf_win = 1'b1; have = 1'b1; a = pend_q[0].a; d = pend_q[0].d;
      end else if (cpu_wen) begin
        have = 1'b1; a = cpu_waddr; d = cpu_wdata;
      end
      e_stall = cpu_wen && e_buf_win;
    end
    e_wen  = have && (a != 5'd0);
    e_addr = e_wen ? a : 5'd0;
    e_data = e_wen ? d : 32'd0;
  endtask

  task automatic model_advance();
    bit    accept;
    beat_t b;
    if (e_wen) begin
      exp_rf[e_addr] = e_data;
      exp_valid[e_addr] = 1'b1;
    end
    accept = dbg_valid && e_ready;
    if (m_clear) begin
      m_done = (m_clr_n == 30);
      m_clr_n++;
      if (m_clr_n == 31) begin
        m_clear = 1'b0;
        m_clr_n = 0;
      end
    end else begin
      m_done = 1'b0;
      if (e_buf_win) begin
        void'(pend_q.pop_front());
      end else if (pend_q.size() > 0 && cpu_wen) begin
        b = pend_q[0];
        b.lost++;
        pend_q[0] = b;
      end
      if (CLR_EN && clr_start) begin
        m_clear = 1'b1;
        m_clr_n = 0;
      end
    end
    if (accept) begin
      b.a = dbg_waddr; b.d = dbg_wdata; b.lost = 0;
      pend_q.push_back(b);
    end
  endtask

  task automatic rnd_cycle();
    logic [36:0] w;
    model_eval();
    if (e_wen) exp_q.push_back({e_addr, e_data});
    @(negedge clk);
    chk("rnd_out", dut_out(), mk_out(e_stall, e_ready, e_busy, e_done, e_wen, e_addr, e_data));
    if (rf_wen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rnd_write: got write 0x%0h to r%0d, expected no write", rf_wdata, rf_waddr);
      end else begin
        w = exp_q.pop_front();
        chk("rnd_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, w});
      end
    end
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic rnd_drive(input int cpu_pct);
    if (!(cpu_wen && e_stall)) begin
      cpu_wen   = ($urandom_range(99, 0) < cpu_pct);
      cpu_waddr = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
      cpu_wdata = $urandom;
    end
    if (!(dbg_valid && !e_ready)) begin
      dbg_valid = ($urandom_range(99, 0) < 30);
      dbg_waddr = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
      dbg_wdata = $urandom;
    end
    clr_start = ($urandom_range(299, 0) == 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    do_reset();

    // Directed table (expected outputs assume STARVE_LIMIT = 4).
    vecs.push_back(mk(0, 0, 0,             0, 0,  0,             0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 5, 32'h12345678,  0, 0,  0,             0, 1, 1, 5, 32'h12345678));
    vecs.push_back(mk(0, 0, 0,             1, 7,  32'hDEADBEEF,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,             0, 0,  0,             0, 0, 1, 7, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0,             0, 0,  0,             0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h11,        1, 9,  32'hA5A5A5A5,  0, 1, 1, 1, 32'h11));
    vecs.push_back(mk(1, 2, 32'h22,        1, 10, 32'h0BAD0BAD,  0, 0, 1, 2, 32'h22));
    vecs.push_back(mk(1, 3, 32'h33,        0, 0,  0,             0, 0, 1, 3, 32'h33));
    vecs.push_back(mk(1, 4, 32'h44,        0, 0,  0,             0, 0, 1, 4, 32'h44));
    vecs.push_back(mk(1, 6, 32'h66,        0, 0,  0,             0, 0, 1, 6, 32'h66));
    vecs.push_back(mk(1, 8, 32'h88,        0, 0,  0,             1, 0, 1, 9, 32'hA5A5A5A5));
    vecs.push_back(mk(1, 8, 32'h88,        0, 0,  0,             0, 1, 1, 8, 32'h88));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF,  1, 0,  32'hCAFEF00D,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,             0, 0,  0,             0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,             0, 0,  0,             0, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cpu_wen = vecs[i].cw; cpu_waddr = vecs[i].ca; cpu_wdata = vecs[i].cd;
      dbg_valid = vecs[i].dv; dbg_waddr = vecs[i].da; dbg_wdata = vecs[i].dd;
      clr_start = 1'b0;
      cyc_chk($sformatf("vec%0d", i),
              mk_out(vecs[i].st, vecs[i].rdy, 1'b0, 1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd));
    end
    drive_idle();
    chk("rd_r5", {32'd0, mock_rf[5]}, 64'h12345678);
    chk("rd_r7", {32'd0, mock_rf[7]}, 64'hDEADBEEF);
    chk("rd_r9", {32'd0, mock_rf[9]}, 64'hA5A5A5A5);
    chk("rd_r8", {32'd0, mock_rf[8]}, 64'h88);
    chk("r0_never_written", 64'(r0_writes), 64'd0);

    // clr_start must be ignored in a build without the clear feature.
    if (!CLR_EN) begin
      clr_start = 1'b1;
      cyc_chk("clr_ignored_a", mk_out(0, 1, 0, 0, 0, 5'd0, 32'd0));
      clr_start = 1'b0;
      cyc_chk("clr_ignored_b", mk_out(0, 1, 0, 0, 0, 5'd0, 32'd0));
    end

`ifdef RF_CLEAR_EN
    // Full clear with the CPU requesting throughout.
    for (int i = 1; i < 32; i++) begin
      cpu_drive(5'(i), 32'h10000000 | 32'(i));
      cyc_chk("preload", mk_out(0, 1, 0, 0, 1, 5'(i), 32'h10000000 | 32'(i)));
    end
    drive_idle();
    clr_start = 1'b1;
    cyc_chk("clr_start", mk_out(0, 1, 0, 0, 0, 5'd0, 32'd0));
    clr_start = 1'b0;
    cpu_drive(5'd3, 32'hBEEF);
    for (int k = 1; k < 32; k++)
      cyc_chk($sformatf("clr_w%0d", k), mk_out(1, 1, 1, 0, 1, 5'(k), 32'd0));
    cyc_chk("clr_done", mk_out(0, 1, 0, 1, 1, 5'd3, 32'hBEEF));
    drive_idle();
    cyc_chk("clr_after", mk_out(0, 1, 0, 0, 0, 5'd0, 32'd0));
    for (int i = 1; i < 32; i++)
      chk($sformatf("clr_r%0d", i), {32'd0, mock_rf[i]}, (i == 3) ? 64'hBEEF : 64'd0);

    // Reset in the middle of a clear, while r10 is being addressed.
    for (int i = 1; i < 32; i++) begin
      cpu_drive(5'(i), 32'h20000000 | 32'(i));
      cyc_chk("preload2", mk_out(0, 1, 0, 0, 1, 5'(i), 32'h20000000 | 32'(i)));
    end
    drive_idle();
    clr_start = 1'b1;
    cyc_chk("clr_start2", mk_out(0, 1, 0, 0, 0, 5'd0, 32'd0));
    clr_start = 1'b0;
    for (int k = 1; k < 10; k++)
      cyc_chk($sformatf("clr2_w%0d", k), mk_out(0, 1, 1, 0, 1, 5'(k), 32'd0));
    @(negedge clk);
    chk("clr2_ptr10", dut_out(), mk_out(0, 1, 1, 0, 1, 5'd10, 32'd0));
    #1 rst = 1'b1;
    #1 chk("rst_abort", dut_out(), mk_out(0, 1, 0, 0, 0, 5'd0, 32'd0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 1; i < 32; i++)
      chk($sformatf("abort_r%0d", i), {32'd0, mock_rf[i]},
          (i < 10) ? 64'd0 : {32'd0, 32'h20000000 | 32'(i)});
    cpu_drive(5'd12, 32'h77);
    cyc_chk("post_abort_idle", mk_out(0, 1, 0, 0, 1, 5'd12, 32'h77));
    drive_idle();
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rnd_drive((c < 1500) ? 60 : 92);
      rnd_cycle();
    end
    drive_idle();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 32; i++)
      if (exp_valid[i]) chk($sformatf("rnd_rf_r%0d", i), {32'd0, mock_rf[i]}, {32'd0, exp_rf[i]});
    chk("r0_never_written_rnd", 64'(r0_writes), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single synchronous write port between the multi-cycle CPU's writeback stage and a debug/loader master, and optionally sequences a full register-file clear. Sits directly in front of the regfile write port (wen/waddr/wdata). CPU writeback has priority, but starvation of the debug master is bounded. Writes to r0 are swallowed so r0 stays zero.

## Interface
- STARVE_LIMIT, 4: consecutive lost conflicts after which the debug master wins one conflict; legal 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_wen  in  1  CPU writeback request, held until not stalled.
- cpu_waddr  in  5  CPU destination register.
- cpu_wdata  in  32  CPU write data.
- cpu_stall  out  1  CPU write not performed this cycle; combinational.
- dbg_valid  in  1  debug write offered.
- dbg_ready  out  1  holding buffer empty; combinational from state.
- dbg_waddr  in  5  debug destination register.
- dbg_wdata  in  32  debug write data.
- clr_start  in  1  start clear sequence (single-cycle pulse or level).
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.
- rf_wen  out  1  to regfile wen; combinational.
- rf_waddr  out  5  to regfile waddr.
- rf_wdata  out  32  to regfile wdata.

## Operation
- States: IDLE, CLEAR. Reset -> IDLE, buffer empty, starve counter 0, clear pointer 1.
- Debug buffer: one entry {addr, data}. Accepted on clk edge when dbg_valid && dbg_ready. dbg_ready = buffer empty.
- IDLE arbitration each cycle, candidates = CPU (cpu_wen) and buffer (full):
  - Only one candidate: it is granted.
  - Both: CPU granted unless starve counter == STARVE_LIMIT, then buffer granted.
  - Starve counter: +1 on each cycle the buffer loses a conflict (saturating at STARVE_LIMIT); cleared to 0 when buffer is granted.
- Granted source drives rf_waddr/rf_wdata; rf_wen = 1 unless granted waddr == 0 (request consumed, no write).
- Buffer granted -> buffer empties at that edge; a new dbg beat may be accepted the following cycle (no same-cycle refill).
- cpu_stall = cpu_wen && CPU not granted. Ungranted rf_waddr/rf_wdata = 0 when rf_wen = 0.
- CLEAR: clr_start in IDLE enters CLEAR on next edge. Each CLEAR cycle: rf_wen=1, rf_waddr=pointer, rf_wdata=0; pointer 1..31, 31 cycles. After write to 31 -> IDLE, pointer back to 1, clr_done pulses the first IDLE cycle.
- In CLEAR: clr_busy=1, cpu_stall=cpu_wen, buffer held (not granted, counter frozen), dbg accepted only if buffer empty.
- clr_start while in CLEAR ignored; clr_start held high re-triggers one cycle after clr_done... i.e. on the cycle clr_done is high, a high clr_start enters CLEAR again.

## Timing
- Reset values: cpu_stall=0 (cpu_wen=0), dbg_ready=1, clr_busy=0, clr_done=0, rf_wen=0, rf_waddr=0, rf_wdata=0. Reset mid-CLEAR aborts immediately; partially cleared registers keep state.
- CPU write: zero added latency; written on the edge of the cycle it is granted.
- Debug write: accepted edge N, earliest regfile write at edge N+1; worst case under continuous CPU writes, edge N+1+STARVE_LIMIT.
- Clear: clr_start sampled edge N; writes at edges N+1..N+31; clr_done high cycle after edge N+31.

## Configuration
- RF_CLEAR_EN defined: CLEAR state, pointer and clr_* logic present as above.
- Undefined: clr_start ignored, clr_busy and clr_done tied 0, FSM reduces to IDLE only; arbitration unchanged.

## Test plan
- After rst release: dbg_ready=1, rf_wen=0; single CPU write r5=0x12345678 -> rf_wen=1 same cycle, cpu_stall=0, readback r5=0x12345678.
- Debug write r7=0xDEADBEEF with no CPU traffic -> accepted edge N, rf_wen with waddr 7 at edge N+1, dbg_ready back to 1 the cycle after.
- STARVE_LIMIT=4, continuous cpu_wen plus one pending debug beat -> CPU wins 4 conflicts, 5th cycle debug granted and cpu_stall=1 for exactly that cycle.
- CPU write to r0 with 0xFFFFFFFF and debug write to r0 -> rf_wen=0, cpu_stall=0, buffer drains, r0 reads 0.
- RF_CLEAR_EN: preload r1..r31 nonzero, pulse clr_start -> clr_busy high 31 cycles, addresses 1..31 written with 0, clr_done one cycle, cpu_wen during it stalls throughout.
- Assert rst at CLEAR pointer=10 -> clr_busy drops immediately, r11..r31 retain values, FSM in IDLE.
